// File: rtl/approx_adder_pkg.sv
// Shared definitions for the pipelined approximate adder with error monitor.
//   MAX_W          : widest operand the helper functions handle (WIDTH <= MAX_W)
//   STAT_CNT_MAX_W : widest statistics counter supported (CNT_W <= STAT_CNT_MAX_W)
//   stats_t        : statistics record {samples, viols, max_err, sticky}
//   loa_sum        : lower-part-OR approximate sum
//   abs_diff       : unsigned |x - y|
package approx_adder_pkg;

    localparam int MAX_W          = 32;
    localparam int STAT_CNT_MAX_W = 32;
    localparam int STAT_ERR_MAX_W = MAX_W + 1;

    // Fields are sized for the widest instance; narrower instances keep the
    // upper bits at zero and slice on the way out.
    typedef struct packed {
        logic [STAT_CNT_MAX_W-1:0] samples;
        logic [STAT_CNT_MAX_W-1:0] viols;
        logic [STAT_ERR_MAX_W-1:0] max_err;
        logic                      sticky;
    } stats_t;

    // Low k bits are OR-ed, the carry into the exact upper part is the AND
    // of the two top approximated bits. k = 0 degenerates to the exact sum.
    function automatic logic [MAX_W:0] loa_sum(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input int               k);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] kbit;
        logic [MAX_W-1:0] lo;
        logic             cin;
        logic [MAX_W:0]   hi;
        if (k <= 0) begin
            return {1'b0, a} + {1'b0, b};
        end
        mask = MAX_W'((64'd1 << k) - 64'd1);
        kbit = MAX_W'(1) << (k - 1);
        lo   = (a | b) & mask;
        cin  = |(a & b & kbit);
        hi   = {1'b0, a >> k} + {1'b0, b >> k} + {{MAX_W{1'b0}}, cin};
        return (hi << k) | {1'b0, lo};
    endfunction

    function automatic logic [MAX_W:0] abs_diff(input logic [MAX_W:0] x,
                                                input logic [MAX_W:0] y);
        return (x > y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/approx_adder_pipe_etmon_if.sv
// Operand / result stream bundle for approx_adder_pipe_etmon.
//   in_valid/in_ready/in_a/in_b/in_mode : operand stream (mode 1 = approximate)
//   out_valid/out_ready/out_sum/out_err/out_viol : result stream
// master = upstream/downstream environment, slave = the adder.
interface approx_adder_pipe_etmon_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
    logic [WIDTH:0]   out_err;
    logic             out_viol;

    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready,
        input  in_ready, out_valid, out_sum, out_err, out_viol
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready,
        output in_ready, out_valid, out_sum, out_err, out_viol
    );
endinterface

// File: rtl/approx_adder_stats.sv
// Runtime error statistics, updated only when a result is handed off.
//   hs      : result handshake this cycle (out_valid & out_ready)
//   viol    : handed-off result exceeds the error threshold
//   err     : handed-off result's absolute error
//   clr     : synchronous clear; wins over a coincident handshake
//   samples, viols : saturating counters; max_err : largest err seen;
//   sticky  : set by the first violation, cleared by clr or reset
module approx_adder_stats
    import approx_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hs,
    input  logic             viol,
    input  logic [WIDTH:0]   err,
    input  logic             clr,
    output logic [CNT_W-1:0] samples,
    output logic [CNT_W-1:0] viols,
    output logic [WIDTH:0]   max_err,
    output logic             sticky
);
    localparam logic [63:0]               CNT_SAT64 = (64'd1 << CNT_W) - 64'd1;
    localparam logic [STAT_CNT_MAX_W-1:0] CNT_SAT   = CNT_SAT64[STAT_CNT_MAX_W-1:0];
    localparam logic [STAT_CNT_MAX_W-1:0] CNT_ONE   = STAT_CNT_MAX_W'(1);

    stats_t                    stats_reg;
    stats_t                    stats_next;
    logic [STAT_ERR_MAX_W-1:0] err_ext;

    assign err_ext = STAT_ERR_MAX_W'(err);

    always_comb begin
        stats_next = stats_reg;
        if (clr) begin
            stats_next = '0;
        end else if (hs) begin
            if (stats_reg.samples != CNT_SAT) begin
                stats_next.samples = stats_reg.samples + CNT_ONE;
            end
            if (viol && (stats_reg.viols != CNT_SAT)) begin
                stats_next.viols = stats_reg.viols + CNT_ONE;
            end
            if (err_ext > stats_reg.max_err) begin
                stats_next.max_err = err_ext;
            end
            stats_next.sticky = stats_reg.sticky | viol;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stats_reg <= '0;
        end else begin
            stats_reg <= stats_next;
        end
    end

    assign samples = stats_reg.samples[CNT_W-1:0];
    assign viols   = stats_reg.viols[CNT_W-1:0];
    assign max_err = stats_reg.max_err[WIDTH:0];
    assign sticky  = stats_reg.sticky;

endmodule

// File: rtl/approx_adder_pipe_etmon.sv
// Two-stage pipelined exact / lower-part-OR approximate adder with per-result
// absolute-error reporting and in-system error statistics.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : operand/result stream (slave side), see the interface file
//   stat_clr    : synchronous clear of the statistics
//   stat_samples, stat_viols, stat_max_err, viol_sticky : statistics outputs
// Stage 1 registers the operands and mode; stage 2 computes both sums and
// the error and registers the result. No skid buffer: in_ready is a
// combinational function of out_ready.
module approx_adder_pipe_etmon
    import approx_adder_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_LSBS = 2,
    parameter int ET          = 5,
    parameter int CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    approx_adder_pipe_etmon_if.slave   bus,
    input  logic                       stat_clr,
    output logic [CNT_W-1:0]           stat_samples,
    output logic [CNT_W-1:0]           stat_viols,
    output logic [WIDTH:0]             stat_max_err,
    output logic                       viol_sticky
);
    localparam logic [WIDTH:0] ET_V = (WIDTH+1)'(ET);

    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    logic             s1_mode_reg;

    logic             out_valid_reg;
    logic [WIDTH:0]   out_sum_reg;
    logic [WIDTH:0]   out_err_reg;
    logic             out_viol_reg;

    logic             adv1;
    logic             adv2;

    logic [WIDTH:0]   exact_sum;
    logic [WIDTH:0]   approx_sum;
    logic [WIDTH:0]   sum_next;
    logic [WIDTH:0]   err_next;
    logic             viol_next;

    assign adv2 = !out_valid_reg || bus.out_ready;
    assign adv1 = !s1_valid_reg || adv2;

    always_comb begin
        exact_sum  = {1'b0, s1_a_reg} + {1'b0, s1_b_reg};
        approx_sum = (WIDTH+1)'(loa_sum(MAX_W'(s1_a_reg), MAX_W'(s1_b_reg), APPROX_LSBS));
        sum_next   = exact_sum;
        err_next   = '0;
        viol_next  = 1'b0;
        if (s1_mode_reg) begin
            sum_next  = approx_sum;
            err_next  = (WIDTH+1)'(abs_diff(STAT_ERR_MAX_W'(approx_sum),
                                            STAT_ERR_MAX_W'(exact_sum)));
            viol_next = (err_next > ET_V);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_a_reg      <= '0;
            s1_b_reg      <= '0;
            s1_mode_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            out_sum_reg   <= '0;
            out_err_reg   <= '0;
            out_viol_reg  <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid_reg <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_a_reg    <= bus.in_a;
                    s1_b_reg    <= bus.in_b;
                    s1_mode_reg <= bus.in_mode;
                end
            end
            // Result registers only load when a new result moves in, so a
            // stalled result stays put.
            if (adv2) begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_sum_reg  <= sum_next;
                    out_err_reg  <= err_next;
                    out_viol_reg <= viol_next;
                end
            end
        end
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_sum   = out_sum_reg;
    assign bus.out_err   = out_err_reg;
    assign bus.out_viol  = out_viol_reg;

    approx_adder_stats #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_stats (
        .clk     (clk),
        .rst_n   (rst_n),
        .hs      (out_valid_reg && bus.out_ready),
        .viol    (out_viol_reg),
        .err     (out_err_reg),
        .clr     (stat_clr),
        .samples (stat_samples),
        .viols   (stat_viols),
        .max_err (stat_max_err),
        .sticky  (viol_sticky)
    );

endmodule

// File: tb/tb_approx_adder_pipe_etmon.sv
// Bench for approx_adder_pipe_etmon. Two instances share one input stream:
//   dut_a : WIDTH=8, APPROX_LSBS=2, ET=5, CNT_W=16
//   dut_b : WIDTH=8, APPROX_LSBS=4, ET=5, CNT_W=4
// Expected results come from an arithmetic reference model of the LOA rule.
module tb_approx_adder_pipe_etmon;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid = 1'b0;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic       in_mode = 1'b0;
    logic       out_ready = 1'b0;
    logic       stat_clr = 1'b0;

    logic [15:0] samples_a, viols_a;
    logic [8:0]  max_a;
    logic        sticky_a;
    logic [3:0]  samples_b, viols_b;
    logic [8:0]  max_b;
    logic        sticky_b;

    approx_adder_pipe_etmon_if #(.WIDTH(8)) bus_a ();
    approx_adder_pipe_etmon_if #(.WIDTH(8)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_a      = in_a;
    assign bus_a.in_b      = in_b;
    assign bus_a.in_mode   = in_mode;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_a      = in_a;
    assign bus_b.in_b      = in_b;
    assign bus_b.in_mode   = in_mode;
    assign bus_b.out_ready = out_ready;

    approx_adder_pipe_etmon #(.WIDTH(8), .APPROX_LSBS(2), .ET(5), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .stat_clr(stat_clr),
        .stat_samples(samples_a), .stat_viols(viols_a),
        .stat_max_err(max_a), .viol_sticky(sticky_a)
    );

    approx_adder_pipe_etmon #(.WIDTH(8), .APPROX_LSBS(4), .ET(5), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .stat_clr(stat_clr),
        .stat_samples(samples_b), .stat_viols(viols_b),
        .stat_max_err(max_b), .viol_sticky(sticky_b)
    );

    int checks = 0;
    int errors = 0;

    int         obs_lat;
    logic [8:0] obs_sum_a, obs_err_a, obs_sum_b, obs_err_b;
    logic       obs_viol_a, obs_viol_b;

    // Reference model: low k bits OR-ed, carry-in from AND of bit k-1,
    // upper part added exactly.
    function automatic int ref_sum(input int a, input int b, input int m, input int k);
        int lo, cin, hi;
        if (m == 0 || k == 0) return a + b;
        lo  = (a % (1 << k)) | (b % (1 << k));
        cin = ((a >> (k - 1)) & 1) & ((b >> (k - 1)) & 1);
        hi  = (a >> k) + (b >> k) + cin;
        return hi * (1 << k) + lo;
    endfunction

    function automatic int ref_err(input int a, input int b, input int m, input int k);
        int d;
        d = ref_sum(a, b, m, k) - (a + b);
        return (d < 0) ? -d : d;
    endfunction

    // Drives one transaction into an idle pipeline with out_ready high and
    // records what both instances produce. Starts and ends just after a posedge.
    task automatic run_txn(input int a, input int b, input int m);
        in_valid = 1'b1; in_a = 8'(a); in_b = 8'(b); in_mode = m[0]; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        obs_lat = 99;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (bus_a.out_valid) begin
                obs_lat = n;
                break;
            end
        end
        obs_sum_a = bus_a.out_sum; obs_err_a = bus_a.out_err; obs_viol_a = bus_a.out_viol;
        obs_sum_b = bus_b.out_sum; obs_err_b = bus_b.out_err; obs_viol_b = bus_b.out_viol;
        @(posedge clk); #1;
        $display("txn a=%0d b=%0d mode=%0d lat=%0d sum_a=%0d err_a=%0d sum_b=%0d err_b=%0d viol_b=%0d",
                 a, b, m, obs_lat, obs_sum_a, obs_err_a, obs_sum_b, obs_err_b, obs_viol_b);
    endtask

    task automatic clear_stats();
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus_a.out_valid !== 1'b0 || bus_b.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %0d/%0d expected 0", bus_a.out_valid, bus_b.out_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_a.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %0d expected 1", bus_a.in_ready);
        end
        checks++;
        if (samples_a !== 16'd0 || viols_a !== 16'd0 || max_a !== 9'd0 || sticky_a !== 1'b0) begin
            errors++; $display("FAIL reset_stats got %0d %0d %0d %0d expected 0", samples_a, viols_a, max_a, sticky_a);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        run_txn(3, 3, 1);
        checks++;
        if (obs_lat != 2) begin errors++; $display("FAIL latency got %0d expected 2", obs_lat); end
        checks++;
        if (obs_sum_a !== 9'(ref_sum(3, 3, 1, 2)) || obs_err_a !== 9'(ref_err(3, 3, 1, 2)) || obs_viol_a !== 1'b0) begin
            errors++; $display("FAIL lat_approx got sum %0d err %0d expected %0d %0d", obs_sum_a, obs_err_a,
                               ref_sum(3, 3, 1, 2), ref_err(3, 3, 1, 2));
        end
        run_txn(3, 3, 0);
        checks++;
        if (obs_sum_a !== 9'd6 || obs_err_a !== 9'd0 || obs_lat != 2) begin
            errors++; $display("FAIL lat_exact got sum %0d err %0d lat %0d expected 6 0 2", obs_sum_a, obs_err_a, obs_lat);
        end
    endtask

    task automatic test_wide();
        int ta[3] = '{255, 255, 1};
        int tb[3] = '{255, 255, 2};
        int tm[3] = '{1, 0, 1};
        for (int i = 0; i < 3; i++) begin
            run_txn(ta[i], tb[i], tm[i]);
            checks++;
            if (obs_sum_a !== 9'(ref_sum(ta[i], tb[i], tm[i], 2)) || obs_err_a !== 9'(ref_err(ta[i], tb[i], tm[i], 2))) begin
                errors++; $display("FAIL wide_a[%0d] got sum %0d err %0d expected %0d %0d", i, obs_sum_a, obs_err_a,
                                   ref_sum(ta[i], tb[i], tm[i], 2), ref_err(ta[i], tb[i], tm[i], 2));
            end
            checks++;
            if (obs_sum_b !== 9'(ref_sum(ta[i], tb[i], tm[i], 4)) || obs_err_b !== 9'(ref_err(ta[i], tb[i], tm[i], 4))) begin
                errors++; $display("FAIL wide_b[%0d] got sum %0d err %0d expected %0d %0d", i, obs_sum_b, obs_err_b,
                                   ref_sum(ta[i], tb[i], tm[i], 4), ref_err(ta[i], tb[i], tm[i], 4));
            end
        end
    endtask

    task automatic test_threshold();
        int e1, e2;
        clear_stats();
        run_txn(7, 7, 1);
        e1 = ref_err(7, 7, 1, 4);
        checks++;
        if (obs_sum_b !== 9'(ref_sum(7, 7, 1, 4)) || obs_err_b !== 9'(e1) || obs_viol_b !== 1'(e1 > 5)) begin
            errors++; $display("FAIL thr_first got sum %0d err %0d viol %0d expected %0d %0d %0d",
                               obs_sum_b, obs_err_b, obs_viol_b, ref_sum(7, 7, 1, 4), e1, e1 > 5);
        end
        checks++;
        if (sticky_b !== 1'b1 || viols_b !== 4'd1) begin
            errors++; $display("FAIL thr_sticky got sticky %0d viols %0d expected 1 1", sticky_b, viols_b);
        end
        run_txn(15, 1, 1);
        e2 = ref_err(15, 1, 1, 4);
        checks++;
        if (obs_sum_b !== 9'(ref_sum(15, 1, 1, 4)) || obs_err_b !== 9'(e2) || obs_viol_b !== 1'b0) begin
            errors++; $display("FAIL thr_second got sum %0d err %0d viol %0d expected %0d %0d 0",
                               obs_sum_b, obs_err_b, obs_viol_b, ref_sum(15, 1, 1, 4), e2);
        end
        checks++;
        if (max_b !== 9'((e1 > e2) ? e1 : e2) || viols_b !== 4'd1 || samples_b !== 4'd2) begin
            errors++; $display("FAIL thr_stats got max %0d viols %0d samples %0d expected %0d 1 2",
                               max_b, viols_b, samples_b, (e1 > e2) ? e1 : e2);
        end
    endtask

    task automatic test_random();
        int a, b, m;
        for (int i = 0; i < 8; i++) begin
            a = $urandom_range(0, 255); b = $urandom_range(0, 255); m = $urandom_range(0, 1);
            run_txn(a, b, m);
            checks++;
            if (obs_lat != 2 || obs_sum_a !== 9'(ref_sum(a, b, m, 2)) || obs_err_a !== 9'(ref_err(a, b, m, 2))
                || obs_viol_a !== 1'(ref_err(a, b, m, 2) > 5)) begin
                errors++; $display("FAIL rand_a[%0d] got sum %0d err %0d lat %0d expected %0d %0d 2", i,
                                   obs_sum_a, obs_err_a, obs_lat, ref_sum(a, b, m, 2), ref_err(a, b, m, 2));
            end
            checks++;
            if (obs_sum_b !== 9'(ref_sum(a, b, m, 4)) || obs_err_b !== 9'(ref_err(a, b, m, 4))
                || obs_viol_b !== 1'(ref_err(a, b, m, 4) > 5)) begin
                errors++; $display("FAIL rand_b[%0d] got sum %0d err %0d viol %0d expected %0d %0d", i,
                                   obs_sum_b, obs_err_b, obs_viol_b, ref_sum(a, b, m, 4), ref_err(a, b, m, 4));
            end
        end
    endtask

    task automatic test_back_to_back();
        int   exp_sum[$];
        int   exp_err[$];
        int   sent = 0, got = 0, cyc = 0, es, ee;
        logic stalled = 1'b0, hs;
        logic [8:0] held_sum, held_err;
        clear_stats();
        in_valid = 1'b1; in_a = 8'($urandom_range(0, 255)); in_b = 8'($urandom_range(0, 255));
        in_mode = 1'($urandom_range(0, 1));
        while (got < 6 && cyc < 300) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
            if (bus_a.out_valid) begin
                if (stalled) begin
                    checks++;
                    if (bus_a.out_sum !== held_sum || bus_a.out_err !== held_err) begin
                        errors++; $display("FAIL b2b_stable got %0d/%0d expected %0d/%0d",
                                           bus_a.out_sum, bus_a.out_err, held_sum, held_err);
                    end
                end
                if (out_ready) begin
                    checks++;
                    if (exp_sum.size() == 0) begin
                        errors++; $display("FAIL b2b_extra got sum %0d expected no result", bus_a.out_sum);
                    end else begin
                        es = exp_sum.pop_front(); ee = exp_err.pop_front();
                        if (bus_a.out_sum !== 9'(es) || bus_a.out_err !== 9'(ee)) begin
                            errors++; $display("FAIL b2b_result[%0d] got %0d/%0d expected %0d/%0d",
                                               got, bus_a.out_sum, bus_a.out_err, es, ee);
                        end
                    end
                    $display("txn b2b[%0d] sum=%0d err=%0d", got, bus_a.out_sum, bus_a.out_err);
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled  = 1'b1;
                    held_sum = bus_a.out_sum;
                    held_err = bus_a.out_err;
                end
            end
            hs = in_valid && bus_a.in_ready;
            @(posedge clk); #1;
            if (hs) begin
                exp_sum.push_back(ref_sum(in_a, in_b, in_mode, 2));
                exp_err.push_back(ref_err(in_a, in_b, in_mode, 2));
                sent++;
                if (sent < 6) begin
                    in_a = 8'($urandom_range(0, 255)); in_b = 8'($urandom_range(0, 255));
                    in_mode = 1'($urandom_range(0, 1));
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b1;
        checks++;
        if (got != 6 || exp_sum.size() != 0) begin
            errors++; $display("FAIL b2b_count got %0d results expected 6", got);
        end
        checks++;
        if (samples_a !== 16'd6 || samples_b !== 4'd6) begin
            errors++; $display("FAIL b2b_samples got %0d/%0d expected 6", samples_a, samples_b);
        end
    endtask

    task automatic test_stat_clr();
        clear_stats();
        run_txn(7, 7, 1);
        checks++;
        if (samples_a !== 16'd1 || sticky_b !== 1'b1) begin
            errors++; $display("FAIL clr_pre got samples %0d sticky %0d expected 1 1", samples_a, sticky_b);
        end
        in_valid = 1'b1; in_a = 8'd7; in_b = 8'd7; in_mode = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        stat_clr = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_a.out_valid !== 1'b1) begin
            errors++; $display("FAIL clr_hs_valid got %0d expected 1", bus_a.out_valid);
        end
        @(posedge clk); #1;
        stat_clr = 1'b0;
        checks++;
        if (samples_a !== 16'd0 || samples_b !== 4'd0 || viols_b !== 4'd0 || max_b !== 9'd0 || sticky_b !== 1'b0) begin
            errors++; $display("FAIL clr_priority got %0d %0d %0d %0d %0d expected 0", samples_a, samples_b,
                               viols_b, max_b, sticky_b);
        end
        checks++;
        if (bus_a.out_valid !== 1'b0) begin
            errors++; $display("FAIL clr_consumed got out_valid %0d expected 0", bus_a.out_valid);
        end
    endtask

    task automatic test_saturation();
        clear_stats();
        out_ready = 1'b1; in_valid = 1'b1; in_a = 8'd7; in_b = 8'd7; in_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (samples_b !== 4'd15 || viols_b !== 4'd15) begin
            errors++; $display("FAIL sat_b got samples %0d viols %0d expected 15 15", samples_b, viols_b);
        end
        checks++;
        if (samples_a !== 16'd20 || viols_a !== 16'd0 || max_a !== 9'(ref_err(7, 7, 1, 2))) begin
            errors++; $display("FAIL sat_a got samples %0d viols %0d max %0d expected 20 0 %0d",
                               samples_a, viols_a, max_a, ref_err(7, 7, 1, 2));
        end
    endtask

    task automatic test_reset_midstream();
        int a, b;
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 1'b1;
        in_a = 8'($urandom_range(0, 255)); in_b = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
        in_a = 8'($urandom_range(0, 255)); in_b = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.in_ready !== 1'b0) begin
            errors++; $display("FAIL mid_inflight got valid %0d ready %0d expected 1 0", bus_a.out_valid, bus_a.in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus_a.out_valid !== 1'b0 || bus_b.out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_async_valid got %0d/%0d expected 0", bus_a.out_valid, bus_b.out_valid);
        end
        checks++;
        if (samples_a !== 16'd0 || samples_b !== 4'd0 || max_a !== 9'd0 || sticky_b !== 1'b0) begin
            errors++; $display("FAIL mid_async_stats got %0d %0d %0d %0d expected 0", samples_a, samples_b, max_a, sticky_b);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        a = $urandom_range(0, 255); b = $urandom_range(0, 255);
        run_txn(a, b, 1);
        checks++;
        if (obs_lat != 2 || obs_sum_a !== 9'(ref_sum(a, b, 1, 2)) || obs_sum_b !== 9'(ref_sum(a, b, 1, 4))) begin
            errors++; $display("FAIL mid_after got lat %0d sum %0d/%0d expected 2 %0d/%0d", obs_lat,
                               obs_sum_a, obs_sum_b, ref_sum(a, b, 1, 2), ref_sum(a, b, 1, 4));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_latency();
        test_wide();
        test_threshold();
        test_random();
        test_back_to_back();
        test_stat_clr();
        test_saturation();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
